// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Response codes, FSM state encodings and register index width.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int REG_IDX_W = 2;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register array: one write port, one combinational read port,
// and a flattened parallel export of all registers.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [REG_IDX_W-1:0]       widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [REG_IDX_W-1:0]       ridx,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read sees pre-write contents, so a same-edge read returns the old value
  assign rdata = regs_q[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder over a 4-entry register file.
// Independent write (AW/W/B) and read (AR/R) handshake FSMs.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [3:0]                 AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [3:0]                 ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic                 aw_held_q, aw_held_d;
  logic                 w_held_q, w_held_d;
  logic [REG_IDX_W-1:0] awidx_q, awidx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic                 aw_hs, w_hs, ar_hs;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_widx;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    rf_rdata;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{AWADDR[1:0], ARADDR[1:0]};

  axi4_lite_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .we     (rf_we),
    .widx   (rf_widx),
    .wdata  (rf_wdata),
    .ridx   (ARADDR[3:2]),
    .rdata  (rf_rdata),
    .regs_o (regs_o)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // Address and data may arrive in either order; commit once both exist
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    rf_we      = 1'b0;
    rf_widx    = awidx_q;
    rf_wdata   = wdata_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = AWADDR[3:2];
          rf_widx   = AWADDR[3:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          rf_wdata = WDATA;
        end
        if ((aw_hs | aw_held_q) & (w_hs | w_held_q)) begin
          rf_we      = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rf_rdata;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = ARESETn & (wr_state_q == WR_IDLE) & ~aw_held_q;
    WREADY  = ARESETn & (wr_state_q == WR_IDLE) & ~w_held_q;
    BVALID  = (wr_state_q == WR_RESP);
    BRESP   = RESP_OKAY;
  end

  always_comb begin
    ARREADY = ARESETn & (rd_state_q == RD_IDLE);
    RVALID  = (rd_state_q == RD_DATA);
    RDATA   = rdata_q;
    RRESP   = RESP_OKAY;
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: vector table of single
// writes/reads plus hand-written ordering, stall, collision and reset cases.
module tb_axi4_lite_slave_regs;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [3:0]   AWADDR = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b1;
  logic [3:0]   ARADDR = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b1;
  logic [127:0] regs_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_regs dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .regs_o  (regs_o)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          exp_idx;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          input int idx);
    AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    chk("wr_awready", AWREADY, 1'b1);
    chk("wr_wready", WREADY, 1'b1);
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_bvalid", BVALID, 1'b1);
    chk("wr_bresp", BRESP, 2'b00);
    chk("wr_reg", regs_o[idx*32 +: 32], d);
    step();
    chk("wr_bvalid_drop", BVALID, 1'b0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] d);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    chk("rd_arready", ARREADY, 1'b1);
    step();
    ARVALID = 1'b0;
    chk("rd_rvalid", RVALID, 1'b1);
    chk("rd_rdata", RDATA, d);
    chk("rd_rresp", RRESP, 2'b00);
    step();
    chk("rd_rvalid_drop", RVALID, 1'b0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 1};
    vecs[1] = '{1'b1, 4'h9, 32'hCAFEF00D, 2};
    vecs[2] = '{1'b1, 4'h0, 32'h00000001, 0};
    vecs[3] = '{1'b0, 4'h4, 32'hDEADBEEF, 1};
    vecs[4] = '{1'b0, 4'hA, 32'hCAFEF00D, 2};
    vecs[5] = '{1'b0, 4'h3, 32'h00000001, 0};
    vecs[6] = '{1'b0, 4'hC, 32'h00000000, 3};

    // Reset state
    step();
    step();
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_regs", regs_o, 128'h0);
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    ARESETn = 1'b1;
    step();
    chk("post_rst_awready", AWREADY, 1'b1);
    chk("post_rst_wready", WREADY, 1'b1);
    chk("post_rst_arready", ARREADY, 1'b1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_idx);
      else do_read(vecs[i].addr, vecs[i].data);
    end

    // W arrives first, AW three cycles later
    WDATA = 32'h12345678; WVALID = 1'b1;
    step();
    WVALID = 1'b0;
    chk("wfirst_wready_low", WREADY, 1'b0);
    chk("wfirst_awready_high", AWREADY, 1'b1);
    chk("wfirst_no_bvalid", BVALID, 1'b0);
    step();
    step();
    chk("wfirst_still_wait", BVALID, 1'b0);
    chk("wfirst_reg3_old", regs_o[127:96], 32'h0);
    AWADDR = 4'hC; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("wfirst_bvalid", BVALID, 1'b1);
    chk("wfirst_reg3", regs_o[127:96], 32'h12345678);
    step();
    chk("wfirst_bvalid_pulse", BVALID, 1'b0);
    chk("wfirst_ready_back", {AWREADY, WREADY}, 2'b11);

    // Read with RREADY stalled for 4 cycles
    RREADY = 1'b0; ARADDR = 4'h4; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_rvalid", RVALID, 1'b1);
      chk("stall_rdata", RDATA, 32'hDEADBEEF);
      chk("stall_arready", ARREADY, 1'b0);
      step();
    end
    RREADY = 1'b1;
    chk("stall_rvalid_pre", RVALID, 1'b1);
    step();
    chk("stall_done", RVALID, 1'b0);

    // Same-edge write and read of reg0: read returns the old value
    AWADDR = 4'h0; WDATA = 32'hA5A5A5A5; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 4'h0; ARVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("coll_bvalid", BVALID, 1'b1);
    chk("coll_rvalid", RVALID, 1'b1);
    chk("coll_rdata_old", RDATA, 32'h00000001);
    chk("coll_reg0_new", regs_o[31:0], 32'hA5A5A5A5);
    step();
    do_read(4'h0, 32'hA5A5A5A5);

    // Reset while a write response is pending
    BREADY = 1'b0;
    AWADDR = 4'h8; WDATA = 32'h00000055; AWVALID = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("rstmid_bvalid", BVALID, 1'b1);
    step();
    chk("rstmid_bvalid_hold", BVALID, 1'b1);
    chk("rstmid_ready_low", {AWREADY, WREADY}, 2'b00);
    ARESETn = 1'b0;
    step();
    chk("rstmid_bvalid_drop", BVALID, 1'b0);
    chk("rstmid_regs", regs_o, 128'h0);
    ARESETn = 1'b1;
    BREADY = 1'b1;
    #1;
    chk("rstmid_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    step();
    do_read(4'h4, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite responder with a 4-entry, 32-bit register file. It serves both write channels (AW/W/B) and read channels (AR/R), and is the peer of the team's AXI4-Lite master on the 4-bit-address peripheral bus. Register contents are exported in parallel so peripheral logic can consume the control/config words directly.

## Interface
- NUM_REGS, 4, register count; fixed at 4 because it is indexed by address bits [3:2]
- DATA_W, 32, register and bus data width
- ACLK  in  1  clock; all state changes on the rising edge
- ARESETn  in  1  reset: synchronous, active-low, clock ACLK
- AWADDR  in  4  write address; byte address, bits [1:0] ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  32  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response; always 2'b00 (OKAY)
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  4  read address; bits [1:0] ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  32  read data
- RRESP  out  2  read response; always 2'b00 (OKAY)
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- regs_o  out  NUM_REGS*DATA_W  register file contents; reg i occupies bits [32*i+31 : 32*i]

## Operation
- Reset values: all registers 0, BVALID 0, RVALID 0, RDATA 0, BRESP and RRESP 2'b00.
- While ARESETn = 0, AWREADY, WREADY and ARREADY are 0.
- Write FSM, states WR_IDLE and WR_RESP:
  - WR_IDLE: AWREADY = !aw_held and WREADY = !w_held.
  - An AW handshake latches AWADDR[3:2] and sets aw_held.
  - A W handshake latches WDATA and sets w_held.
  - AW and W may arrive in either order, or in the same cycle.
  - On the edge where both address and data are available (held, or handshaking now), write reg[addr[3:2]] and go to WR_RESP.
  - WR_RESP: BVALID = 1, AWREADY = WREADY = 0.
  - On BVALID && BREADY, clear aw_held/w_held and return to WR_IDLE.
- Read FSM, states RD_IDLE and RD_DATA:
  - RD_IDLE: ARREADY = 1.
  - On an AR handshake, register RDATA = reg[ARADDR[3:2]] and go to RD_DATA.
  - RD_DATA: RVALID = 1, ARREADY = 0. RDATA is held stable until RVALID && RREADY, then return to RD_IDLE.
- The two FSMs are independent. Each allows at most one outstanding transaction.
- BRESP/RRESP are always OKAY. The address space is fully decoded, so no SLVERR exists.

## Timing
- Write latency: BVALID rises the cycle after the last of the AW/W handshakes. The register update is visible on regs_o in that same cycle.
- Read latency: RVALID and RDATA are valid the cycle after the AR handshake.
- Minimum throughput is 2 cycles per write (BREADY held high) and 2 cycles per read (RREADY held high).
- Ready outputs depend only on state and flags, never combinationally on the incoming VALIDs. VALID outputs are registered.
- Once BVALID or RVALID is asserted, it and its payload stay stable until the matching READY is seen.
- Read and write commit to the same register on the same edge: the read returns the pre-write value.
- Reset asserted mid-transaction: all held flags and states clear on that edge, pending responses are dropped, and registers return to 0.
- AW held with W never arriving: the block waits indefinitely in WR_IDLE with AWREADY = 0 and WREADY = 1. There is no timeout.

## Structure
- Shared package axi4_lite_pkg:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - wr_state_e and rd_state_e enums
  - REG_IDX_W = 2
- Sub-module axi4_lite_regfile: NUM_REGS × DATA_W array with a synchronous reset, one write port (we, widx, wdata), one combinational read port (ridx, rdata), and a flattened regs_o.
- The top level holds the two handshake FSMs and the capture flags.

## Test plan
- AW and W in the same cycle: addr 4'h4, data 32'hDEADBEEF, BREADY = 1 → BVALID one cycle later with BRESP 00; regs_o[63:32] = DEADBEEF.
- W first (data 32'h12345678), AW 3 cycles later (addr 4'hC) → WREADY low after its handshake, AWREADY still high; reg3 = 12345678; single BVALID pulse.
- Read-back with RREADY stalled: read addr 4'h4 with RREADY = 0 for 4 cycles → RVALID and RDATA = DEADBEEF held stable for all 4 cycles, ARREADY = 0; completes on RREADY.
- Collision: write 32'hA5A5A5A5 to addr 0 and read addr 0 committing on the same edge, with reg0 previously 32'h1 → RDATA = 1; a following read returns A5A5A5A5.
- Unaligned address: write to addr 4'h9 → lands in reg2.
- Reset during WR_RESP with BREADY = 0 → BVALID = 0 the next cycle, all regs_o = 0, AWREADY = WREADY = ARREADY = 1 after ARESETn is released.
